bcd_conv: RTL and testbench

BCD_CONV -- requirements
Module: bcd_conv

---
 rtl/bcd_pkg.sv | 8 +
 rtl/bcd_add3.sv | 9 +
 rtl/bcd_conv.sv | 105 ++++++++++
 tb/tb_bcd_conv.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// bcd_pkg: shared types and constants for the binary-to-BCD converter.
package bcd_pkg;
    localparam int NDIG     = 4;
    localparam int MAX_IN_W = 8;
    localparam int CNT_W    = $clog2(MAX_IN_W + 1);
    typedef logic [3:0] digit_t;
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
endpackage

// File: rtl/bcd_add3.sv
// bcd_add3: double-dabble correction, adds 3 to a BCD digit that is 5 or more.
module bcd_add3
    import bcd_pkg::*;
(
    input  digit_t d_i,
    output digit_t q_o
);
    assign q_o = (d_i >= 4'd5) ? d_i + 4'd3 : d_i;
endmodule

// File: rtl/bcd_conv.sv
// bcd_conv: sequential double-dabble binary-to-BCD converter (IN_W cycles per result).
// Define BCD_CONV_SIGNED_EN to enable two's-complement input and the sinal output.
module bcd_conv
    import bcd_pkg::*;
#(
    parameter int IN_W = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [IN_W-1:0] value,
    input  logic            is_signed,
    output logic            busy,
    output logic            done,
    output digit_t          d0,
    output digit_t          d1,
    output digit_t          d2,
    output digit_t          d3,
    output logic            sinal
);
    localparam int BCD_W = 4 * (NDIG - 1);

    state_t state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [BCD_W-1:0] bcd_q, bcd_d, dig_q, dig_d, sh_bcd;
    logic [IN_W-1:0]  bin_q, bin_d, sh_bin;
    logic [IN_W:0]    mag;
    logic             neg, fin, unused_ok;
    digit_t           adj [NDIG-1];

    for (genvar g = 0; g < NDIG - 1; g++) begin : g_add3
        bcd_add3 u_add3 (.d_i(bcd_q[4*g +: 4]), .q_o(adj[g]));
    end

    // The top digit never exceeds 2 for an 8-bit magnitude, so its MSB is dropped.
    assign sh_bcd = {adj[2][2:0], adj[1], adj[0], bin_q[IN_W-1]};
    assign sh_bin = {bin_q[IN_W-2:0], 1'b0};
    assign mag    = neg ? -{value[IN_W-1], value} : {1'b0, value};
    assign fin    = (state_q == SHIFT) && (cnt_q == CNT_W'(1));

`ifdef BCD_CONV_SIGNED_EN
    logic sign_q, sinal_q;
    assign neg       = is_signed & value[IN_W-1];
    assign sinal     = sinal_q;
    assign unused_ok = ^{mag[IN_W], adj[2][3]};
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sign_q  <= 1'b0;
            sinal_q <= 1'b0;
        end else begin
            if (state_q == IDLE && start) sign_q <= neg;
            if (fin) sinal_q <= sign_q;
        end
    end
`else
    assign neg       = 1'b0;
    assign sinal     = 1'b0;
    assign unused_ok = ^{mag[IN_W], adj[2][3], is_signed};
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bcd_d   = bcd_q;
        bin_d   = bin_q;
        dig_d   = dig_q;
        if (state_q == IDLE && start) begin
            state_d = SHIFT;
            cnt_d   = CNT_W'(IN_W);
            bcd_d   = '0;
            bin_d   = mag[IN_W-1:0];
        end else if (state_q == SHIFT) begin
            bcd_d   = sh_bcd;
            bin_d   = sh_bin;
            cnt_d   = cnt_q - 1'b1;
            state_d = fin ? DONE : SHIFT;
            dig_d   = fin ? sh_bcd : dig_q;
        end else if (state_q == DONE) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bcd_q   <= '0;
            bin_q   <= '0;
            dig_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bcd_q   <= bcd_d;
            bin_q   <= bin_d;
            dig_q   <= dig_d;
        end
    end

    assign busy = (state_q != IDLE);
    assign done = (state_q == DONE);
    assign d0   = dig_q[3:0];
    assign d1   = dig_q[7:4];
    assign d2   = dig_q[11:8];
    assign d3   = '0;
endmodule

// File: tb/tb_bcd_conv.sv
// tb_bcd_conv: randomized self-checking bench for bcd_conv against a decimal reference model.
module tb_bcd_conv;
    logic       clk = 1'b0;
    logic       rst, start, is_signed;
    logic [7:0] value;
    logic       busy, done, sinal;
    logic [3:0] d0, d1, d2, d3;
    int n_checks = 0;
    int n_fail   = 0;

    bcd_conv #(.IN_W(8)) dut (
        .clk(clk), .rst(rst), .start(start), .value(value), .is_signed(is_signed),
        .busy(busy), .done(done), .d0(d0), .d1(d1), .d2(d2), .d3(d3), .sinal(sinal)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic bit neg_of(input int v, input bit s);
`ifdef BCD_CONV_SIGNED_EN
        return s && v >= 128;
`else
        return 1'b0;
`endif
    endfunction

    function automatic int mag_of(input int v, input bit s);
        return neg_of(v, s) ? 256 - v : v;
    endfunction

    task automatic check_res(input string tag, input int v, input bit s);
        int m;
        m = mag_of(v, s);
        check({tag, "_d0"}, d0, m % 10);
        check({tag, "_d1"}, d1, (m / 10) % 10);
        check({tag, "_d2"}, d2, m / 100);
        check({tag, "_d3"}, d3, 0);
        check({tag, "_sinal"}, sinal, neg_of(v, s));
    endtask

    task automatic conv(input logic [7:0] v, input bit s, input string tag);
        int n;
        bit busy_ok;
        value = v; is_signed = s; start = 1'b1;
        n = 0; busy_ok = 1'b1;
        do begin
            @(posedge clk); #1;
            start = 1'b0;
            n++;
            if (!done && !busy) busy_ok = 1'b0;
        end while (!done && n < 30);
        check({tag, "_lat"}, n, 9);
        check({tag, "_busy"}, busy_ok, 1);
        check_res(tag, v, s);
        @(posedge clk); #1;
        check({tag, "_pulse"}, done, 0);
    endtask

    initial begin
        int n, pulses, at;
        bit busy_ok;
        int perm [256];
        rst = 1'b0; start = 1'b0; value = '0; is_signed = 1'b0;
        #12;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_d0", d0, 0);
        check("rst_d1", d1, 0);
        check("rst_d2", d2, 0);
        check("rst_d3", d3, 0);
        check("rst_sinal", sinal, 0);
        rst = 1'b1;
        @(posedge clk); #1;

        conv(8'hFF, 1'b0, "ff_u");
        conv(8'h80, 1'b1, "80_s");
        conv(8'hF9, 1'b1, "f9_s");
        conv(8'h00, 1'b1, "00_s");
        conv(8'h7B, 1'b0, "7b_u");

        // start re-pulsed during SHIFT must be ignored
        value = 8'h2A; is_signed = 1'b0; start = 1'b1;
        pulses = 0; at = 0; busy_ok = 1'b1;
        for (int i = 1; i <= 25; i++) begin
            @(posedge clk); #1;
            start = 1'b0;
            if (i == 3) begin value = 8'h10; start = 1'b1; end
            if (done) begin pulses++; if (at == 0) at = i; end
            if (at == 0 && !busy) busy_ok = 1'b0;
            if (i == 9) check_res("ign", 42, 1'b0);
        end
        check("ign_pulses", pulses, 1);
        check("ign_lat", at, 9);
        check("ign_busy", busy_ok, 1);
        check_res("ign_hold", 42, 1'b0);

        // reset in the middle of SHIFT
        value = 8'h55; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        check("mid_busy", busy, 0);
        check("mid_done", done, 0);
        check_res("mid", 0, 1'b0);
        #1 rst = 1'b1;
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (done) pulses++;
        end
        check("mid_nodone", pulses, 0);
        conv(8'h63, 1'b0, "63_u");

        // start held high over shuffled full sweeps, both sign modes
        for (int s = 0; s < 2; s++) begin
            for (int i = 0; i < 256; i++) perm[i] = i;
            for (int i = 255; i > 0; i--) begin
                int j, t;
                j = $urandom_range(i, 0);
                t = perm[i]; perm[i] = perm[j]; perm[j] = t;
            end
            is_signed = s[0]; value = perm[0][7:0]; start = 1'b1;
            for (int i = 0; i < 256; i++) begin
                n = 0;
                do begin
                    @(posedge clk); #1;
                    n++;
                end while (!done && n < 30);
                check($sformatf("sw%0d_%0d_gap", s, perm[i]), n, (i == 0) ? 9 : 10);
                check_res($sformatf("sw%0d_%0d", s, perm[i]), perm[i], s[0]);
                if (i < 255) value = perm[i+1][7:0];
            end
            start = 1'b0;
            repeat (3) @(posedge clk);
            #1;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
